// File: rtl/vlan_tag_parser_pkg.sv
// Shared types for the streaming L2 header parser: ethertype, FSM states, result record.
package vlan_tag_parser_pkg;

   typedef logic [15:0] ethertype_t;

   localparam ethertype_t TPID_CTAG_DEF = 16'h8100;
   localparam ethertype_t TPID_STAG_DEF = 16'h88A8;
   localparam logic [4:0] ETH_HDR_LEN   = 5'd14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ETYPE,
      ST_TCI,
      ST_RESULT,
      ST_DRAIN
   } vlan_state_e;

   typedef struct packed {
      logic [2:0]  tag_count;
      logic [11:0] outer_vid;
      logic [11:0] inner_vid;
      ethertype_t  ethertype;
      logic [4:0]  len;
      logic        err_trunc;
      logic        err_tags;
   } vlan_result_t;

   function automatic logic [4:0] hdr_len(input logic [2:0] tags);
      return ETH_HDR_LEN + {tags, 2'b00};
   endfunction

endpackage

// File: rtl/vlan_tag_parser_if.sv
// Byte stream in, parse result out, plus FSM state for observation.
// VLAN_PCP_EN adds outer_pcp/outer_dei to the result side.
interface vlan_tag_parser_if;
   import vlan_tag_parser_pkg::*;

   // Both sides use strict valid/ready: a transfer happens on a clock edge where
   // valid && ready; valid and its payload hold steady until that edge.
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_sof;
   logic        s_last;
   logic        s_ready;

   logic        res_valid;
   logic        res_ready;
   logic        vlan_present;
   logic [2:0]  tag_count;
   logic [11:0] outer_vid;
   logic [11:0] inner_vid;
   ethertype_t  resolved_ethertype;
   logic [4:0]  l2_header_len;
   logic        err_trunc;
   logic        err_tags;
`ifdef VLAN_PCP_EN
   logic [2:0]  outer_pcp;
   logic        outer_dei;
`endif
   vlan_state_e state;

`ifdef VLAN_PCP_EN
   modport master (
      output s_data, s_valid, s_sof, s_last, res_ready,
      input  s_ready, res_valid, vlan_present, tag_count, outer_vid, inner_vid,
             resolved_ethertype, l2_header_len, err_trunc, err_tags,
             outer_pcp, outer_dei, state
   );
   modport slave (
      input  s_data, s_valid, s_sof, s_last, res_ready,
      output s_ready, res_valid, vlan_present, tag_count, outer_vid, inner_vid,
             resolved_ethertype, l2_header_len, err_trunc, err_tags,
             outer_pcp, outer_dei, state
   );
`else
   modport master (
      output s_data, s_valid, s_sof, s_last, res_ready,
      input  s_ready, res_valid, vlan_present, tag_count, outer_vid, inner_vid,
             resolved_ethertype, l2_header_len, err_trunc, err_tags, state
   );
   modport slave (
      input  s_data, s_valid, s_sof, s_last, res_ready,
      output s_ready, res_valid, vlan_present, tag_count, outer_vid, inner_vid,
             resolved_ethertype, l2_header_len, err_trunc, err_tags, state
   );
`endif

endinterface

// File: rtl/vlan_tag_parser.sv
// Skips DA/SA, walks up to MAX_TAGS stacked VLAN tags, reports the L2 header summary.
// VLAN_PCP_EN adds outer PCP/DEI capture from tag 0.
module vlan_tag_parser
   import vlan_tag_parser_pkg::*;
#(
   parameter int         MAX_TAGS  = 2,
   parameter ethertype_t TPID_CTAG = TPID_CTAG_DEF,
   parameter ethertype_t TPID_STAG = TPID_STAG_DEF
) (
   input logic              clk,
   input logic              rst,
   vlan_tag_parser_if.slave bus
);

   localparam logic [2:0] MAX_TAGS_L = 3'(MAX_TAGS);

   vlan_state_e  state;
   logic [3:0]   byte_cnt;
   logic [7:0]   hi_byte;
   vlan_result_t res;
   logic         res_valid;
   logic         in_ready;
   logic         last_seen;
`ifdef VLAN_PCP_EN
   logic [2:0]   outer_pcp;
   logic         outer_dei;
`endif

   ethertype_t word;
   logic       take;
   logic       is_tpid;
   logic       tag_room;
   logic       hdr_done;
   logic       cut_short;

   // word is only meaningful on the second byte of an ethertype or TCI pair
   assign word      = {hi_byte, bus.s_data};
   assign take      = bus.s_valid && in_ready;
   assign is_tpid   = (word == TPID_CTAG) || ((word == TPID_STAG) && (res.tag_count == 3'd0));
   assign tag_room  = res.tag_count < MAX_TAGS_L;
   assign hdr_done  = (state == ST_ETYPE) && byte_cnt[0] && !(is_tpid && tag_room);
   assign cut_short = bus.s_last && !hdr_done &&
                      ((state == ST_ADDR) || (state == ST_ETYPE) || (state == ST_TCI));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         byte_cnt  <= '0;
         hi_byte   <= '0;
         res       <= '0;
         res_valid <= 1'b0;
         in_ready  <= 1'b0;
         last_seen <= 1'b0;
`ifdef VLAN_PCP_EN
         outer_pcp <= '0;
         outer_dei <= 1'b0;
`endif
      end else if (state == ST_RESULT) begin
         if (bus.res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= last_seen ? ST_IDLE : ST_DRAIN;
         end
      end else begin
         in_ready <= 1'b1;
         if (take && bus.s_sof) begin
            // a new frame always wins, whatever was in flight
            res       <= '0;
`ifdef VLAN_PCP_EN
            outer_pcp <= '0;
            outer_dei <= 1'b0;
`endif
            byte_cnt  <= 4'd1;
            last_seen <= bus.s_last;
            if (bus.s_last) begin
               res.err_trunc <= 1'b1;
               res_valid     <= 1'b1;
               in_ready      <= 1'b0;
               state         <= ST_RESULT;
            end else begin
               state <= ST_ADDR;
            end
         end else if (take) begin
            case (state)
               ST_ADDR: begin
                  if (byte_cnt == 4'd11) begin
                     byte_cnt <= 4'd0;
                     state    <= ST_ETYPE;
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                  end
               end
               ST_ETYPE: begin
                  if (!byte_cnt[0]) begin
                     hi_byte  <= bus.s_data;
                     byte_cnt <= 4'd1;
                  end else begin
                     byte_cnt      <= 4'd0;
                     res.ethertype <= word;
                     res.len       <= hdr_len(res.tag_count);
                     if (is_tpid && tag_room) begin
                        state <= ST_TCI;
                     end else begin
                        res.err_tags <= is_tpid;
                        res_valid    <= 1'b1;
                        in_ready     <= 1'b0;
                        last_seen    <= bus.s_last;
                        state        <= ST_RESULT;
                     end
                  end
               end
               ST_TCI: begin
                  if (!byte_cnt[0]) begin
                     hi_byte  <= bus.s_data;
                     byte_cnt <= 4'd1;
                  end else begin
                     byte_cnt <= 4'd0;
                     if (res.tag_count == 3'd0) begin
                        res.outer_vid <= word[11:0];
`ifdef VLAN_PCP_EN
                        outer_pcp     <= hi_byte[7:5];
                        outer_dei     <= hi_byte[4];
`endif
                     end else if (res.tag_count == 3'd1) begin
                        res.inner_vid <= word[11:0];
                     end
                     res.tag_count <= res.tag_count + 3'd1;
                     res.len       <= hdr_len(res.tag_count + 3'd1);
                     state         <= ST_ETYPE;
                  end
               end
               ST_DRAIN: begin
                  if (bus.s_last) state <= ST_IDLE;
               end
               default: ;
            endcase
            // frame ended before the header did: report what was gathered
            if (cut_short) begin
               res.err_trunc <= 1'b1;
               res_valid     <= 1'b1;
               in_ready      <= 1'b0;
               last_seen     <= 1'b1;
               state         <= ST_RESULT;
            end
         end
      end
   end

   assign bus.s_ready            = in_ready;
   assign bus.res_valid          = res_valid;
   assign bus.vlan_present       = (res.tag_count != 3'd0);
   assign bus.tag_count          = res.tag_count;
   assign bus.outer_vid          = res.outer_vid;
   assign bus.inner_vid          = res.inner_vid;
   assign bus.resolved_ethertype = res.ethertype;
   assign bus.l2_header_len      = res.len;
   assign bus.err_trunc          = res.err_trunc;
   assign bus.err_tags           = res.err_tags;
`ifdef VLAN_PCP_EN
   assign bus.outer_pcp          = outer_pcp;
   assign bus.outer_dei          = outer_dei;
`endif
   assign bus.state              = state;

endmodule
